parallel_serial_lanes: RTL and testbench

PARALLEL_SERIAL_LANES -- requirements
Module: parallel_serial_lanes

---
 rtl/parallel_serial_pkg.sv | 14 +
 rtl/parallel_serial_lanes.sv | 91 +++++++++
 tb/tb_parallel_serial_lanes.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/parallel_serial_pkg.sv
// Shared types and helpers for the parallel-to-serial lane converter.
package parallel_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ps_state_e;

    // Counter width helper: a single-beat word still needs a 1-bit counter.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parallel_serial_lanes.sv
// Parallel word in, LANES-wide beats out, with valid/ready on both sides.
//   state | meaning
//   IDLE  | no word held, upstream may load
//   SHIFT | word held, beats presented on serial_o
module parallel_serial_lanes
    import parallel_serial_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int LANES      = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clk_en_i,
    input  logic                  parallel_valid_i,
    output logic                  parallel_ready_o,
    input  logic [WORD_WIDTH-1:0] parallel_i,
    output logic                  serial_valid_o,
    input  logic                  serial_ready_i,
    output logic [LANES-1:0]      serial_o,
    output logic                  serial_last_o
);

    localparam int             BEATS    = WORD_WIDTH / LANES;
    localparam int             CW       = clog2_min1(BEATS);
    localparam logic [CW-1:0]  LAST_CNT = CW'(BEATS - 1);

    if (LANES < 1 || (WORD_WIDTH % LANES) != 0) begin : g_bad_lanes
        $error("parallel_serial_lanes: WORD_WIDTH must be a positive multiple of LANES");
    end

    ps_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [WORD_WIDTH-1:0] shreg_q;
    logic [WORD_WIDTH-1:0] shreg_next;
    logic [LANES-1:0]      group;
    logic                  is_last;
    logic                  beat_acc;
    logic                  word_acc;

    if (MSB_FIRST) begin : g_msb
        assign group      = shreg_q[WORD_WIDTH-1 -: LANES];
        assign shreg_next = shreg_q << LANES;
    end else begin : g_lsb
        assign group      = shreg_q[LANES-1:0];
        assign shreg_next = shreg_q >> LANES;
    end

    assign serial_valid_o = (state_q == SHIFT);
    assign serial_o       = serial_valid_o ? group : '0;
    assign is_last        = (cnt_q == LAST_CNT);
    assign serial_last_o  = serial_valid_o && is_last;

    assign beat_acc = clk_en_i && serial_valid_o && serial_ready_i;

    // A new word may land in the same cycle the last beat leaves, so streams have no bubble.
    assign parallel_ready_o = clk_en_i && rst_ni &&
                              ((state_q == IDLE) || (beat_acc && serial_last_o));
    assign word_acc         = parallel_valid_i && parallel_ready_o;

    always_comb begin
        state_d = state_q;
        if (word_acc) begin
            state_d = SHIFT;
        end else if (beat_acc && is_last) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (clk_en_i) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (word_acc) begin
            cnt_q   <= '0;
            shreg_q <= parallel_i;
        end else if (beat_acc && !is_last) begin
            cnt_q   <= cnt_q + 1'b1;
            shreg_q <= shreg_next;
        end
    end

endmodule

// File: tb/tb_parallel_serial_lanes.sv
// Directed vector bench for parallel_serial_lanes in 1-lane MSB-first and 2-lane LSB-first builds.
module tb_parallel_serial_lanes;

    typedef struct {
        bit         d2;
        bit         rst_n;
        bit         en;
        bit         pv;
        logic [7:0] pd;
        bit         sr;
        bit         e_prdy;
        bit         e_sv;
        logic [1:0] e_so;
        bit         e_last;
    } vec_t;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst1_n, en1, pv1, sr1, pr1, sv1, last1;
    logic [7:0] pd1;
    logic [0:0] so1;
    logic       rst2_n, en2, pv2, sr2, pr2, sv2, last2;
    logic [7:0] pd2;
    logic [1:0] so2;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    parallel_serial_lanes #(.WORD_WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst1_n), .clk_en_i(en1),
        .parallel_valid_i(pv1), .parallel_ready_o(pr1), .parallel_i(pd1),
        .serial_valid_o(sv1), .serial_ready_i(sr1), .serial_o(so1), .serial_last_o(last1)
    );

    parallel_serial_lanes #(.WORD_WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) u_dut2 (
        .clk_i(clk_i), .rst_ni(rst2_n), .clk_en_i(en2),
        .parallel_valid_i(pv2), .parallel_ready_o(pr2), .parallel_i(pd2),
        .serial_valid_o(sv2), .serial_ready_i(sr2), .serial_o(so2), .serial_last_o(last2)
    );

    task automatic chk(input string name, input int tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, tag, act, exp);
        end
    endtask

    task automatic row(input bit d2, input bit rst_n, input bit en, input bit pv,
                       input logic [7:0] pd, input bit sr, input bit prdy, input bit sv,
                       input logic [1:0] so, input bit last);
        vec_t v;
        v.d2 = d2; v.rst_n = rst_n; v.en = en; v.pv = pv; v.pd = pd; v.sr = sr;
        v.e_prdy = prdy; v.e_sv = sv; v.e_so = so; v.e_last = last;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk_i);
        if (!v.d2) begin
            rst1_n = v.rst_n; en1 = v.en; pv1 = v.pv; pd1 = v.pd; sr1 = v.sr;
            pv2 = 1'b0; en2 = 1'b1; rst2_n = 1'b1;
        end else begin
            rst2_n = v.rst_n; en2 = v.en; pv2 = v.pv; pd2 = v.pd; sr2 = v.sr;
            pv1 = 1'b0; en1 = 1'b1; rst1_n = 1'b1;
        end
        #1;
        if (!v.d2) begin
            chk("ready1", idx, int'(pr1), int'(v.e_prdy));
            chk("valid1", idx, int'(sv1), int'(v.e_sv));
            chk("serial1", idx, int'(so1), int'(v.e_so));
            chk("last1", idx, int'(last1), int'(v.e_last));
        end else begin
            chk("ready2", idx, int'(pr2), int'(v.e_prdy));
            chk("valid2", idx, int'(sv2), int'(v.e_sv));
            chk("serial2", idx, int'(so2), int'(v.e_so));
            chk("last2", idx, int'(last2), int'(v.e_last));
        end
    endtask

    initial begin
        logic [7:0]  wa5, w3c, wc3, w01;
        logic [15:0] bits;
        int          nb, nl, first, lastc, sent;

        wa5 = 8'hA5; w3c = 8'h3C; wc3 = 8'hC3; w01 = 8'h01;

        // single-lane MSB-first: basic word
        row(0, 0, 1, 1, 8'hA5, 1, 0, 0, 0, 0);
        row(0, 1, 1, 1, 8'hA5, 1, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) row(0, 1, 1, 0, 8'h00, 1, k == 7, 1, {1'b0, wa5[7-k]}, k == 7);
        row(0, 1, 1, 0, 8'h00, 1, 1, 0, 0, 0);
        // back-to-back words, valid held
        row(0, 1, 1, 1, 8'h3C, 1, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) row(0, 1, 1, 1, 8'hC3, 1, k == 7, 1, {1'b0, w3c[7-k]}, k == 7);
        for (int k = 0; k < 8; k++) row(0, 1, 1, 0, 8'h00, 1, k == 7, 1, {1'b0, wc3[7-k]}, k == 7);
        row(0, 1, 1, 0, 8'h00, 1, 1, 0, 0, 0);
        // downstream stall on beat 3
        row(0, 1, 1, 1, 8'hA5, 1, 1, 0, 0, 0);
        row(0, 1, 1, 0, 8'h00, 1, 0, 1, 1, 0);
        row(0, 1, 1, 0, 8'h00, 1, 0, 1, 0, 0);
        for (int s = 0; s < 4; s++) row(0, 1, 1, 0, 8'h00, 0, 0, 1, 1, 0);
        for (int k = 2; k < 8; k++) row(0, 1, 1, 0, 8'h00, 1, k == 7, 1, {1'b0, wa5[7-k]}, k == 7);
        row(0, 1, 1, 0, 8'h00, 1, 1, 0, 0, 0);
        // clock enable toggling
        row(0, 1, 1, 1, 8'hA5, 1, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            row(0, 1, 0, 0, 8'h00, 1, 0, 1, {1'b0, wa5[7-k]}, k == 7);
            row(0, 1, 1, 0, 8'h00, 1, k == 7, 1, {1'b0, wa5[7-k]}, k == 7);
        end
        row(0, 1, 1, 0, 8'h00, 1, 1, 0, 0, 0);
        // reset mid-word, then new word straight away
        row(0, 1, 1, 1, 8'hFF, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) row(0, 1, 1, 0, 8'h00, 1, 0, 1, 1, 0);
        row(0, 0, 1, 0, 8'h00, 1, 0, 1, 1, 0);
        row(0, 1, 1, 1, 8'h01, 1, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) row(0, 1, 1, 0, 8'h00, 1, k == 7, 1, {1'b0, w01[7-k]}, k == 7);
        row(0, 1, 1, 0, 8'h00, 1, 1, 0, 0, 0);
        // reset wins over a low clock enable
        row(0, 1, 1, 1, 8'hFF, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 8'h00, 1, 0, 1, 1, 0);
        row(0, 1, 1, 0, 8'h00, 1, 1, 0, 0, 0);
        // two-lane LSB-first: 0xB4 then 0xB4 chained into 0x1E
        row(1, 0, 1, 0, 8'h00, 1, 0, 0, 0, 0);
        row(1, 1, 1, 1, 8'hB4, 1, 1, 0, 0, 0);
        row(1, 1, 1, 0, 8'h00, 1, 0, 1, 2'b00, 0);
        row(1, 1, 1, 0, 8'h00, 1, 0, 1, 2'b01, 0);
        row(1, 1, 1, 0, 8'h00, 1, 0, 1, 2'b11, 0);
        row(1, 1, 1, 0, 8'h00, 1, 1, 1, 2'b10, 1);
        row(1, 1, 1, 0, 8'h00, 1, 1, 0, 2'b00, 0);
        row(1, 1, 1, 1, 8'hB4, 1, 1, 0, 0, 0);
        row(1, 1, 1, 0, 8'h00, 1, 0, 1, 2'b00, 0);
        row(1, 1, 1, 0, 8'h00, 1, 0, 1, 2'b01, 0);
        row(1, 1, 1, 0, 8'h00, 1, 0, 1, 2'b11, 0);
        row(1, 1, 1, 1, 8'h1E, 1, 1, 1, 2'b10, 1);
        row(1, 1, 1, 0, 8'h00, 1, 0, 1, 2'b10, 0);
        row(1, 1, 1, 0, 8'h00, 1, 0, 1, 2'b11, 0);
        row(1, 1, 1, 0, 8'h00, 1, 0, 1, 2'b01, 0);
        row(1, 1, 1, 0, 8'h00, 1, 1, 1, 2'b00, 1);
        row(1, 1, 1, 0, 8'h00, 1, 1, 0, 2'b00, 0);

        rst1_n = 1'b0; en1 = 1'b1; pv1 = 1'b0; pd1 = '0; sr1 = 1'b1;
        rst2_n = 1'b0; en2 = 1'b1; pv2 = 1'b0; pd2 = '0; sr2 = 1'b1;
        repeat (2) @(posedge clk_i);

        foreach (tbl[i]) apply(tbl[i], i);

        // contiguous stream of 0x3C,0xC3 observed beat by beat
        @(negedge clk_i);
        rst1_n = 1'b1; en1 = 1'b1; sr1 = 1'b1; pv1 = 1'b1; pd1 = 8'h3C;
        bits = '0; nb = 0; nl = 0; first = -1; lastc = -1; sent = 0;
        for (int c = 0; c < 40 && nb < 16; c++) begin
            #1;
            if (sv1) begin
                bits = {bits[14:0], so1};
                nb++;
                if (last1) nl++;
                if (first < 0) first = c;
                lastc = c;
            end
            if (pv1 && pr1) sent++;
            @(negedge clk_i);
            if (sent == 1) pd1 = 8'hC3;
            else if (sent >= 2) pv1 = 1'b0;
        end
        chk("stream_beats", 0, nb, 16);
        chk("stream_bits", 0, int'(bits), 16'h3CC3);
        chk("stream_lasts", 0, nl, 2);
        chk("stream_span", 0, lastc - first + 1, 16);
        pv1 = 1'b0;

        // long stall on the two-lane build, word 0x6C -> 00,11,10,01
        @(negedge clk_i);
        rst2_n = 1'b1; en2 = 1'b1; sr2 = 1'b0; pv2 = 1'b1; pd2 = 8'h6C;
        #1;
        chk("stall_accept", 0, int'(pr2), 1);
        @(negedge clk_i);
        pv2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("stall_hold", c, int'({sv2, so2, last2, pr2}), 5'b1_00_0_0);
            @(negedge clk_i);
        end
        sr2 = 1'b1;
        #1;
        chk("resume_b0", 0, int'({so2, last2}), 3'b00_0);
        @(negedge clk_i); #1;
        chk("resume_b1", 0, int'({so2, last2}), 3'b11_0);
        @(negedge clk_i); #1;
        chk("resume_b2", 0, int'({so2, last2}), 3'b10_0);
        @(negedge clk_i); #1;
        chk("resume_b3", 0, int'({so2, last2, pr2}), 4'b01_1_1);
        @(negedge clk_i); #1;
        chk("resume_idle", 0, int'({sv2, so2}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
